// File: rtl/ntt_mem_sched_pkg.sv
// Shared constants, FSM encodings and index helpers for the NTT memory scheduler.
// The bank layout (4 banks x 512 words) pins LOGN at 11.
package ntt_mem_sched_pkg;

  localparam int LOGN     = 11;
  localparam int NBANK    = 4;
  localparam int ADDRW    = 9;
  localparam int WB_DELAY = 9;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Opens a zero bit at position pos, shifting the higher bits of val up by one.
  function automatic logic [LOGN-1:0] insert_zero(input logic [LOGN-1:0] val,
                                                  input logic [3:0]      pos);
    logic [LOGN-1:0] mask;
    mask = (LOGN'(1) << pos) - LOGN'(1);
    return ((val & ~mask) << 1) | (val & mask);
  endfunction

endpackage

// File: rtl/ntt_mem_sched_bank_map.sv
// Coefficient index -> {bank, in-bank address} for the 4-bank conflict-free layout.
// The bank is the parity of the odd index bits and the parity of the even index bits.
module bank_map
  import ntt_mem_sched_pkg::*;
(
  input  logic [LOGN-1:0]  idx_i,
  output logic [1:0]       bank_o,
  output logic [ADDRW-1:0] addr_o
);

  assign bank_o[1] = idx_i[1] ^ idx_i[3] ^ idx_i[5] ^ idx_i[7] ^ idx_i[9];
  assign bank_o[0] = idx_i[0] ^ idx_i[2] ^ idx_i[4] ^ idx_i[6] ^ idx_i[8] ^ idx_i[10];
  assign addr_o    = idx_i[LOGN-1:2];

endmodule

// File: rtl/ntt_mem_sched.sv
// Stage/group scheduler for an in-place NTT/INTT over a 4-bank coefficient memory:
// one 4-lane read-modify-write per cycle, with a write-back drain between stages.
module ntt_mem_sched
  import ntt_mem_sched_pkg::*;
#(
  parameter int LOGN  = 11,
  parameter int DRAIN = WB_DELAY + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             inv,
  output logic             busy,
  output logic             done,
  output logic             ren,
  output logic             wen,
  output logic [1:0]       newadd0_idx,
  output logic [1:0]       newadd1_idx,
  output logic [1:0]       newadd2_idx,
  output logic [1:0]       newadd3_idx,
  output logic [ADDRW-1:0] newadd0,
  output logic [ADDRW-1:0] newadd1,
  output logic [ADDRW-1:0] newadd2,
  output logic [ADDRW-1:0] newadd3,
  output logic [3:0]       stage,
  output logic [ADDRW-1:0] grp
);

  localparam int         CNTW      = $clog2(DRAIN + 1);
  localparam logic [3:0] TOP_STAGE = 4'(LOGN - 1);

  logic [1:0]       state_q, state_d;
  logic             inv_q, inv_d;
  logic [3:0]       s_q, s_d;
  logic [ADDRW-1:0] g_q, g_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic             busy_q, done_q, ren_q;
  logic [3:0]       stage_q;
  logic [ADDRW-1:0] grp_q;
  logic [1:0]       bank_q [NBANK];
  logic [ADDRW-1:0] addr_q [NBANK];

  logic [3:0]       t_pos, lo_pos, hi_pos;
  logic [LOGN-1:0]  base, bit_s, bit_t;
  logic [LOGN-1:0]  lane_idx  [NBANK];
  logic [1:0]       lane_bank [NBANK];
  logic [ADDRW-1:0] lane_addr [NBANK];
  logic [3:0]       last_stage;

  // The partner bit t has the opposite parity of s, so each lane lands in its own bank.
  assign t_pos  = s_q[0] ? 4'd0 : 4'd1;
  assign lo_pos = (s_q < t_pos) ? s_q : t_pos;
  assign hi_pos = (s_q < t_pos) ? t_pos : s_q;
  assign base   = insert_zero(insert_zero(LOGN'(g_q), lo_pos), hi_pos);
  assign bit_s  = LOGN'(1) << s_q;
  assign bit_t  = LOGN'(1) << t_pos;

  assign lane_idx[0] = base;
  assign lane_idx[1] = base | bit_s;
  assign lane_idx[2] = base | bit_t;
  assign lane_idx[3] = base | bit_s | bit_t;

  for (genvar l = 0; l < NBANK; l++) begin : g_map
    bank_map u_bank_map (
      .idx_i  (lane_idx[l]),
      .bank_o (lane_bank[l]),
      .addr_o (lane_addr[l])
    );
  end

  assign last_stage = inv_q ? TOP_STAGE : 4'd0;

  always_comb begin
    // NOTE: every next-state value defaults to its current value so no latch is inferred.
    state_d = state_q;
    inv_d   = inv_q;
    s_d     = s_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          inv_d   = inv;
          s_d     = inv ? 4'd0 : TOP_STAGE;
          g_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (&g_q) begin
          cnt_d   = CNTW'(DRAIN - 1);
          state_d = S_DRAIN;
        end else begin
          g_d = g_q + ADDRW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          if (s_q == last_stage) begin
            state_d = S_DONE;
          end else begin
            s_d     = inv_q ? s_q + 4'd1 : s_q - 4'd1;
            g_d     = '0;
            state_d = S_RUN;
          end
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      inv_q   <= 1'b0;
      s_q     <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register in this block sees pre-edge values.
      state_q <= state_d;
      inv_q   <= inv_d;
      s_q     <= s_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
    end
  end

  // Issue registers: lane data is captured only while running and held through the drain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ren_q   <= 1'b0;
      stage_q <= '0;
      grp_q   <= '0;
      for (int l = 0; l < NBANK; l++) begin
        bank_q[l] <= '0;
        addr_q[l] <= '0;
      end
    end else begin
      busy_q <= (state_d != S_IDLE);
      done_q <= (state_q == S_DONE);
      ren_q  <= (state_q == S_RUN);
      if (state_q == S_RUN) begin
        stage_q <= s_q;
        grp_q   <= g_q;
        for (int l = 0; l < NBANK; l++) begin
          bank_q[l] <= lane_bank[l];
          addr_q[l] <= lane_addr[l];
        end
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ren         = ren_q;
  assign wen         = ren_q;
  assign stage       = stage_q;
  assign grp         = grp_q;
  assign newadd0_idx = bank_q[0];
  assign newadd1_idx = bank_q[1];
  assign newadd2_idx = bank_q[2];
  assign newadd3_idx = bank_q[3];
  assign newadd0     = addr_q[0];
  assign newadd1     = addr_q[1];
  assign newadd2     = addr_q[2];
  assign newadd3     = addr_q[3];

endmodule

// File: tb/tb_ntt_mem_sched.sv
// Self-checking bench for ntt_mem_sched: a cycle-indexed arithmetic model of the
// schedule is compared against every output on every cycle, plus literal pins.
module tb_ntt_mem_sched;

  localparam int STG   = 512 + 10;
  localparam int TOTAL = 11 * STG + 1;

  logic       clk = 1'b0;
  logic       rstn, start, inv;
  logic       busy, done, ren, wen;
  logic [1:0] b0, b1, b2, b3;
  logic [8:0] a0, a1, a2, a3;
  logic [3:0] stage;
  logic [8:0] grp;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  bit  cmp_en   = 1'b0;
  bit  noise    = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ntt_mem_sched dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .inv         (inv),
    .busy        (busy),
    .done        (done),
    .ren         (ren),
    .wen         (wen),
    .newadd0_idx (b0),
    .newadd1_idx (b1),
    .newadd2_idx (b2),
    .newadd3_idx (b3),
    .newadd0     (a0),
    .newadd1     (a1),
    .newadd2     (a2),
    .newadd3     (a3),
    .stage       (stage),
    .grp         (grp)
  );

  logic [60:0] act_vec, exp_vec;
  assign act_vec = {busy, done, ren, wen, b0, b1, b2, b3, a0, a1, a2, a3, stage, grp};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int model_index(int s, int g, int lane);
    int t   = (s % 2 == 0) ? 1 : 0;
    int idx = 0;
    int gb  = 0;
    for (int p = 0; p < 11; p++) begin
      if (p != s && p != t) begin
        idx = idx | (((g >> gb) & 1) << p);
        gb++;
      end
    end
    if ((lane & 1) != 0) idx = idx | (1 << s);
    if ((lane & 2) != 0) idx = idx | (1 << t);
    return idx;
  endfunction

  function automatic int model_bank(int idx);
    int odd = 0;
    int ev  = 0;
    for (int p = 0; p < 11; p++) begin
      if (((idx >> p) & 1) != 0) begin
        if (p % 2 == 1) odd = odd ^ 1;
        else ev = ev ^ 1;
      end
    end
    return odd * 2 + ev;
  endfunction

  // Recover the coefficient index from a (bank, addr) pair seen on the outputs.
  function automatic int recon(logic [1:0] b, logic [8:0] a);
    int idx = int'(a) << 2;
    int po  = 0;
    int pe  = 0;
    for (int p = 2; p < 11; p++) begin
      if (((idx >> p) & 1) != 0) begin
        if (p % 2 == 1) po = po ^ 1;
        else pe = pe ^ 1;
      end
    end
    return idx | ((int'(b[1]) ^ po) << 1) | (int'(b[0]) ^ pe);
  endfunction

  bit m_active = 1'b0;
  int m_n      = 0;
  bit m_inv    = 1'b0;
  bit e_busy   = 1'b0;
  bit e_done   = 1'b0;
  bit e_ren    = 1'b0;
  int e_stage  = 0;
  int e_grp    = 0;
  int e_bank [4] = '{0, 0, 0, 0};
  int e_addr [4] = '{0, 0, 0, 0};
  int mk, mr, ms;

  // n counts clock edges since the edge that accepted start.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_active = 1'b0;
      m_n      = 0;
      m_inv    = 1'b0;
      e_busy   = 1'b0;
      e_done   = 1'b0;
      e_ren    = 1'b0;
      e_stage  = 0;
      e_grp    = 0;
      for (int l = 0; l < 4; l++) begin
        e_bank[l] = 0;
        e_addr[l] = 0;
      end
    end else begin
      if (m_active) m_n++;
      else if (start === 1'b1) begin
        m_active = 1'b1;
        m_n      = 0;
        m_inv    = inv;
      end
      e_done = 1'b0;
      e_ren  = 1'b0;
      e_busy = 1'b0;
      if (m_active) begin
        e_busy = (m_n < TOTAL);
        e_done = (m_n == TOTAL);
        if (m_n >= 1 && m_n < TOTAL) begin
          mk = (m_n - 1) / STG;
          mr = (m_n - 1) % STG;
          if (mr < 512) begin
            ms      = m_inv ? mk : 10 - mk;
            e_ren   = 1'b1;
            e_stage = ms;
            e_grp   = mr;
            for (int l = 0; l < 4; l++) begin
              e_bank[l] = model_bank(model_index(ms, mr, l));
              e_addr[l] = model_index(ms, mr, l) >> 2;
            end
          end
        end
        if (m_n == TOTAL) m_active = 1'b0;
      end
    end
  end

  assign exp_vec = {e_busy, e_done, e_ren, e_ren,
                    2'(e_bank[0]), 2'(e_bank[1]), 2'(e_bank[2]), 2'(e_bank[3]),
                    9'(e_addr[0]), 9'(e_addr[1]), 9'(e_addr[2]), 9'(e_addr[3]),
                    4'(e_stage), 9'(e_grp)};

  // ---------------- per-cycle compare ----------------
  byte unsigned cov [11][2048];

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle_outputs", 64'(act_vec), 64'(exp_vec));
      if (ren === 1'b1) begin
        check("distinct_banks",
              64'(b0 != b1 && b0 != b2 && b0 != b3 && b1 != b2 && b1 != b3 && b2 != b3),
              64'(1));
        if (stage <= 4'd10) begin
          cov[int'(stage)][recon(b0, a0)]++;
          cov[int'(stage)][recon(b1, a1)]++;
          cov[int'(stage)][recon(b2, a2)]++;
          cov[int'(stage)][recon(b3, a3)]++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
    if (noise) begin
      inv   = 1'($urandom_range(0, 1));
      start = (m_active && m_n > 2 && m_n < 5700 && $urandom_range(0, 31) == 0);
    end
  endtask

  task automatic wait_n(input int target, input string name);
    int guard = 0;
    while (!(m_active && m_n == target) && guard < TOTAL + 100) begin
      tick();
      guard++;
    end
    if (guard >= TOTAL + 100) check({name, "_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic clear_cov();
    for (int s = 0; s < 11; s++)
      for (int i = 0; i < 2048; i++) cov[s][i] = 0;
  endtask

  task automatic issue_start(input bit dir, output int acc);
    noise = 1'b0;
    tick();
    inv   = dir;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc   = cyc;
    start = 1'b0;
  endtask

  task automatic run_transform(input bit dir);
    int acc;
    int dl;
    int guard;
    int bad;
    clear_cov();
    issue_start(dir, acc);
    check("busy_after_start", 64'(busy), 64'(1));
    noise = 1'b1;

    wait_n(1, "first_issue");
    check("first_stage", 64'(stage), dir ? 64'(0) : 64'(10));
    check("first_banks", 64'({b0, b1, b2, b3}), 64'({2'd0, 2'd1, 2'd2, 2'd3}));
    check("first_addrs", 64'({a0, a1, a2, a3}),
          dir ? 64'(0) : 64'({9'd0, 9'd256, 9'd0, 9'd256}));
    check("first_ren_wen", 64'({ren, wen, grp}), 64'({2'b11, 9'd0}));

    wait_n(512, "last_issue");
    check("last_grp", 64'(grp), 64'(511));

    wait_n(513, "drain_start");
    dl = 0;
    while (ren === 1'b0 && dl < 20) begin
      dl++;
      tick();
    end
    check("drain_len", 64'(dl), 64'(10));

    wait_n(1 + STG, "second_stage");
    check("second_stage", 64'(stage), dir ? 64'(1) : 64'(9));
    check("second_banks", 64'({b0, b1, b2, b3}), 64'({2'd0, 2'd2, 2'd1, 2'd3}));
    check("second_addrs", 64'({a0, a1, a2, a3}),
          dir ? 64'(0) : 64'({9'd0, 9'd128, 9'd0, 9'd128}));

    wait_n(1 + 10 * STG, "final_stage");
    check("final_stage", 64'(stage), dir ? 64'(10) : 64'(0));

    guard = 0;
    while (done !== 1'b1 && guard < TOTAL + 50) begin
      tick();
      guard++;
    end
    check("done_latency", 64'(cyc - acc), 64'(TOTAL));
    check("done_busy_low", 64'({done, busy}), 64'(2'b10));
    noise = 1'b0;
    start = 1'b0;
    tick();
    check("done_one_cycle", 64'(done), 64'(0));

    for (int s = 0; s < 11; s++) begin
      bad = 0;
      for (int i = 0; i < 2048; i++) if (cov[s][i] != 1) bad++;
      check($sformatf("coverage_s%0d", s), 64'(bad), 64'(0));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc;
    int tgt;
    rstn  = 1'b0;
    start = 1'b0;
    inv   = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    #1;
    start = 1'b1;
    inv   = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", 64'(act_vec), 64'(0));
    rstn = 1'b1;
    repeat ($urandom_range(2, 6)) tick();
    check("idle_after_release", 64'({busy, ren, done}), 64'(0));

    run_transform(1'b0);
    repeat ($urandom_range(1, 5)) tick();
    run_transform(1'b1);
    repeat ($urandom_range(1, 5)) tick();

    issue_start(1'b0, acc);
    tgt = 1 + 5 * STG + $urandom_range(0, 511);
    wait_n(tgt, "abort_point");
    check("abort_stage_pre", 64'(stage), 64'(5));
    rstn = 1'b0;
    #1;
    check("abort_outputs", 64'(act_vec), 64'(0));
    repeat (2) tick();
    rstn = 1'b1;
    repeat (4) tick();
    check("abort_idle", 64'({busy, ren}), 64'(0));

    issue_start(1'b0, acc);
    wait_n(1, "restart_issue");
    check("restart_stage", 64'({stage, grp, ren}), 64'({4'd10, 9'd0, 1'b1}));
    wait_n(600, "restart_run");
    check("restart_stage9", 64'(stage), 64'(9));

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
